logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (AND, OR, NOT, NOR, XOR, XNOR, NAND) between two requesters.
- Round-robin arbitration; valid/ready handshakes on both request ports and on a single response port.
- Sits between the requesting blocks and the shared gate datapath. It sequences grant, execute and response through a 3-state FSM.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  3  requester 0 opcode
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req1_valid  input  1  requester 1 has an operation pending
req1_ready  output  1  requester 1 operation accepted this cycle
req1_op  input  3  requester 1 opcode
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_data  output  WIDTH  result
rsp_id  output  1  requester that issued the result (0/1)
rsp_err  output  1  opcode was illegal (7)

Behaviour:
- Opcode map: 0 AND, 1 OR, 2 NOT(A) (B ignored), 3 NOR, 4 XOR, 5 XNOR, 6 NAND, 7 illegal.
- An illegal opcode gives rsp_data = 0 and rsp_err = 1.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any reqN_valid is high, assert the granted reqN_ready combinationally for exactly that cycle.
  - Latch op, a, b and id into internal registers, then go to EXEC.
  - At most one ready is high per cycle.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not equal to last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - last_grant updates on every accept.
- EXEC:
  - Compute the result from the latched operands into the rsp_data/rsp_err registers.
  - Set rsp_valid = 1 and go to RESP. This state always takes one cycle.
- RESP:
  - Hold rsp_valid, rsp_data, rsp_id and rsp_err stable while rsp_ready = 0.
  - When rsp_valid and rsp_ready are both high, clear rsp_valid and go to IDLE.
  - No new accept happens in the same cycle as the response handshake.
- Latency:
  - Accept at cycle T gives rsp_valid at T+2.
  - Minimum issue interval is 3 cycles when rsp_ready is held high.
- While the FSM is not in IDLE, both reqN_ready are 0 regardless of valid.
- Operands are captured only at accept. Requester input changes after accept have no effect.
- Reset values: req0_ready = 0, req1_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0; internal operand registers = 0.
- Reset mid-operation: from any state the next edge goes to IDLE with all outputs at reset values. An in-flight result is discarded with no response.
- A requester dropping valid before being granted is legal: no accept, no side effect.
- rsp_ready high while rsp_valid is 0 is ignored.

Optional Feature:
- Macro: LOGIC_UNIT_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each) and err_cnt (8 bits).
  - grant_cntN increments on each accept for requester N.
  - err_cnt increments on each accept with op = 7.
  - All counters saturate at all-ones and reset to 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset then single request:
  - Stimulus: rst_n = 0 for 2 cycles, then high; req0 op = 4 (XOR), a = 8'hF0, b = 8'h3C; rsp_ready = 1.
  - Response: req0_ready pulses 1 cycle; rsp_valid 2 cycles later with rsp_data = 8'hCC, rsp_id = 0, rsp_err = 0.
- All opcodes on req1:
  - Stimulus: a = 8'hA5, b = 8'h0F, op 0..7 issued in turn.
  - Response: rsp_data = 05, AF, 5A, 50, AA, 55, FA, 00, with rsp_err = 1 only for op 7.
- Contention:
  - Stimulus: both valid continuously for 4 transactions.
  - Response: grants in order 0, 1, 0, 1; rsp_id matches each grant; one ready per accept only.
- Backpressure:
  - Stimulus: rsp_ready = 0 for 5 cycles after rsp_valid rises.
  - Response: rsp_data/rsp_id held stable and both reqN_ready stay 0; rsp_ready = 1 completes the handshake and returns the FSM to IDLE.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 in EXEC and in RESP.
  - Response: next cycle all outputs are 0 and no response is emitted. After release, the first tie is granted to requester 0.
- Stats build (LOGIC_UNIT_ARB_STATS_EN):
  - Stimulus: 3 req0 accepts, 2 req1 accepts including one op = 7.
  - Response: grant_cnt0 = 3, grant_cnt1 = 2, err_cnt = 1.

Source files
------------

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for logic_unit_arbiter: two valid/ready request
// ports and one valid/ready response port.
interface logic_unit_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters.
// Optional grant/error counters enabled by LOGIC_UNIT_ARB_STATS_EN.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    logic_unit_arbiter_if.slave     bus
`ifdef LOGIC_UNIT_ARB_STATS_EN
    ,
    output logic [15:0]             grant_cnt0,
    output logic [15:0]             grant_cnt1,
    output logic [7:0]              err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;

    logic             grant0;
    logic             grant1;
    logic             ready0;
    logic             ready1;
    logic             accept;
    logic             accept_id;
    logic [2:0]       op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] result;
    logic             result_err;

    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;
    logic             rsp_err_q;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Readies are gated by reset so nothing is accepted while rst_n is low.
    always_comb begin
        ready0    = 1'b0;
        ready1    = 1'b0;
        if (state == IDLE && rst_n) begin
            ready0 = grant0;
            ready1 = grant1;
        end
        accept    = ready0 || ready1;
        accept_id = ready1;
    end

    always_comb begin
        op_sel = accept_id ? bus.req1_op : bus.req0_op;
        a_sel  = accept_id ? bus.req1_a  : bus.req0_a;
        b_sel  = accept_id ? bus.req1_b  : bus.req0_b;
    end

    always_comb begin
        result_err = 1'b0;
        unique case (op_q)
            3'd0:    result = a_q & b_q;
            3'd1:    result = a_q | b_q;
            3'd2:    result = ~a_q;
            3'd3:    result = ~(a_q | b_q);
            3'd4:    result = a_q ^ b_q;
            3'd5:    result = ~(a_q ^ b_q);
            3'd6:    result = ~(a_q & b_q);
            default: begin
                result     = '0;
                result_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= op_sel;
                a_q        <= a_sel;
                b_q        <= b_sel;
                id_q       <= accept_id;
                last_grant <= accept_id;
            end
            if (state == EXEC) begin
                rsp_data_q  <= result;
                rsp_err_q   <= result_err;
                rsp_id_q    <= id_q;
                rsp_valid_q <= 1'b1;
            end else if (state == RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_err    = rsp_err_q;

`ifdef LOGIC_UNIT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            err_cnt    <= '0;
        end else if (accept) begin
            if (!accept_id && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (accept_id && grant_cnt1 != '1)  grant_cnt1 <= grant_cnt1 + 16'd1;
            if (op_sel == 3'd7 && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed scenarios plus random
// traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_logic_unit_arbiter;

    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.WIDTH(WIDTH)) bus ();

`ifdef LOGIC_UNIT_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    logic [7:0]  err_cnt;
`endif

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef LOGIC_UNIT_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .err_cnt    (err_cnt)
`endif
    );

    typedef struct {
        logic        id;
        logic [7:0]  data;
        logic        err;
        int unsigned acc_cyc;
        bit          seen;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    bit          outstanding = 1'b0;
    bit          model_last = 1'b1;
    int          m_cnt0 = 0;
    int          m_cnt1 = 0;
    int          m_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~(a & b);
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: predict and check the readies at negedge, record accepts,
    // return the readies the DUT actually showed, end at posedge+1.
    task automatic tick(output bit acc0, output bit acc1);
        bit   e0;
        bit   e1;
        exp_t e;
        @(negedge clk);
        acc0 = bus.req0_ready;
        acc1 = bus.req1_ready;
        if (!rst_n) begin
            sb.delete();
            outstanding = 1'b0;
            model_last  = 1'b1;
            m_cnt0 = 0;
            m_cnt1 = 0;
            m_err  = 0;
        end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (!outstanding) begin
                if (bus.req0_valid && (!bus.req1_valid || model_last)) e0 = 1'b1;
                else if (bus.req1_valid) e1 = 1'b1;
            end
            check("req0_ready", bus.req0_ready, e0);
            check("req1_ready", bus.req1_ready, e1);
            if (e0 || e1) begin
                e.id      = e1;
                e.data    = e1 ? ref_result(bus.req1_op, bus.req1_a, bus.req1_b)
                               : ref_result(bus.req0_op, bus.req0_a, bus.req0_b);
                e.err     = e1 ? (bus.req1_op == 3'd7) : (bus.req0_op == 3'd7);
                e.acc_cyc = cyc;
                e.seen    = 1'b0;
                sb.push_back(e);
                model_last  = e1;
                outstanding = 1'b1;
                if (e1) m_cnt1++; else m_cnt0++;
                if (e.err) m_err++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: the head entry must match every cycle rsp_valid is
    // high (which also proves stability under backpressure).
    initial begin
        exp_t e;
        bit   hs;
        forever begin
            @(negedge clk);
            hs = 1'b0;
            if (rst_n && bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_rsp: got rsp_valid=1 data=%0h expected no response", bus.rsp_data);
                end else begin
                    e = sb[0];
                    if (!e.seen) begin
                        check("latency", cyc, e.acc_cyc + 2);
                        sb[0].seen = 1'b1;
                    end
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_id", bus.rsp_id, e.id);
                    check("rsp_err", bus.rsp_err, e.err);
                    if (bus.rsp_ready) begin
                        void'(sb.pop_front());
                        hs = 1'b1;
                    end
                end
            end
            if (hs) begin
                @(posedge clk);
                outstanding = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req0_ready"}, bus.req0_ready, 0);
        check({tag, "_req1_ready"}, bus.req1_ready, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_data"}, bus.rsp_data, 0);
        check({tag, "_rsp_id"}, bus.rsp_id, 0);
        check({tag, "_rsp_err"}, bus.rsp_err, 0);
`ifdef LOGIC_UNIT_ARB_STATS_EN
        check({tag, "_grant_cnt0"}, grant_cnt0, 0);
        check({tag, "_grant_cnt1"}, grant_cnt1, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
`endif
    endtask

    task automatic issue(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bit a0;
        bit a1;
        int n;
        n = 0;
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end
        do begin
            tick(a0, a1);
            n++;
        end while (!(id ? a1 : a0) && n < 50);
        if (!(id ? a1 : a0)) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no ready for requester %0d expected accept", id);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        bit a0;
        bit a1;
        for (int i = 0; i < n; i++) tick(a0, a1);
    endtask

    task automatic pulse_reset(input string tag);
        bit a0;
        bit a1;
        rst_n = 1'b0;
        tick(a0, a1);
        check_reset_outputs(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        bit a0;
        bit a1;
        int accepts;
        int n;
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;

        rst_n = 1'b0;
        tick(a0, a1);
        tick(a0, a1);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Single XOR on requester 0: F0 ^ 3C = CC
        issue(1'b0, 3'd4, 8'hF0, 8'h3C);
        idle_ticks(3);

        // Every opcode on requester 1
        for (int op = 0; op < 8; op++) issue(1'b1, 3'(op), 8'hA5, 8'h0F);
        idle_ticks(3);

        // Contention: last grant was requester 1, so order is 0,1,0,1
        bus.req0_valid = 1'b1; bus.req0_op = 3'($urandom_range(0, 6)); bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
        bus.req1_valid = 1'b1; bus.req1_op = 3'($urandom_range(0, 6)); bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
        accepts = 0;
        n = 0;
        while (accepts < 4 && n < 40) begin
            tick(a0, a1);
            n++;
            if (a0 || a1) begin
                check("contention_grant", {31'd0, a1}, accepts % 2);
                check("one_ready", {31'd0, a0 & a1}, 0);
                accepts++;
                if (a0) bus.req0_a = 8'($urandom);
                if (a1) bus.req1_a = 8'($urandom);
            end
        end
        check("contention_accepts", accepts, 4);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        idle_ticks(3);

        // Backpressure with both requesters waiting
        bus.rsp_ready = 1'b0;
        issue(1'b0, 3'd6, 8'h3C, 8'h5A);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        idle_ticks(8);
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        idle_ticks(4);

        // Reset while in EXEC, then first tie must go to requester 0
        issue(1'b1, 3'd1, 8'h12, 8'h34);
        pulse_reset("rst_exec");
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick(a0, a1);
        check("post_reset_tie", {30'd0, a1, a0}, 32'b01);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        idle_ticks(4);

        // Reset while in RESP with the response stalled
        bus.rsp_ready = 1'b0;
        issue(1'b0, 3'd0, 8'hFF, 8'h81);
        tick(a0, a1);
        pulse_reset("rst_resp");
        bus.rsp_ready = 1'b1;
        idle_ticks(2);

        // Stats scenario: 3 accepts on req0, 2 on req1 including op 7
        issue(1'b0, 3'd0, 8'h11, 8'h22);
        issue(1'b0, 3'd3, 8'h44, 8'h88);
        issue(1'b1, 3'd7, 8'hFF, 8'hFF);
        issue(1'b0, 3'd5, 8'h0F, 8'hF0);
        issue(1'b1, 3'd2, 8'h96, 8'h00);
        idle_ticks(4);
`ifdef LOGIC_UNIT_ARB_STATS_EN
        check("grant_cnt0", grant_cnt0, m_cnt0);
        check("grant_cnt1", grant_cnt1, m_cnt1);
        check("err_cnt", err_cnt, m_err);
`endif

        // Random traffic, including dropped valids and response stalls
        for (int i = 0; i < 400; i++) begin
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req0_op    = 3'($urandom_range(0, 7));
            bus.req0_a     = 8'($urandom);
            bus.req0_b     = 8'($urandom);
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req1_op    = 3'($urandom_range(0, 7));
            bus.req1_a     = 8'($urandom);
            bus.req1_b     = 8'($urandom);
            bus.rsp_ready  = ($urandom_range(0, 3) != 0);
            tick(a0, a1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            tick(a0, a1);
            n++;
        end
        check("drain_empty", sb.size(), 0);
`ifdef LOGIC_UNIT_ARB_STATS_EN
        check("grant_cnt0_final", grant_cnt0, m_cnt0);
        check("grant_cnt1_final", grant_cnt1, m_cnt1);
        check("err_cnt_final", err_cnt, m_err);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
